// File: rtl/spi_slave_rx.sv
// spi_slave_rx
// Receiving end of the 15-bit lab SPI link. Runs entirely in the clk domain:
// SCLK, LOAD and MOSI are synchronized (2 FFs), then edge-detected through a
// registered edge flag, so a pin change acts 4 clk rises after it happens.
//
// Handshake: ok is a one-cycle strobe meaning DO was updated on this same
// cycle; err is a one-cycle strobe meaning the frame ended with a bit count
// other than N and DO was left unchanged. Neither has a ready; the consumer
// must take the strobe on the cycle it is high.
//
// Ports
//   clk       system clock, all state changes on its rising edge
//   clr       asynchronous reset, active-low
//   SCLK      serial clock from the master (asynchronous)
//   LOAD      frame select from the master, active-low (asynchronous)
//   MOSI      serial data from the master, MSB first (asynchronous)
//   MISO      serial data to the master, MSB first
//   DI        word to transmit, captured at frame start
//   DO        last correctly received word
//   ok        DO updated this cycle
//   err       frame ended with a bad bit count
//   busy      frame in progress (state ACTIVE)
//   cb_bit    bits received in the current frame, saturating at N+1
//   state_dbg current FSM state (0 IDLE, 1 ACTIVE, 2 DONE)
module spi_slave_rx #(
    parameter int N  = 15,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          SCLK,
    input  logic          LOAD,
    input  logic          MOSI,
    output logic          MISO,
    input  logic [N-1:0]  DI,
    output logic [N-1:0]  DO,
    output logic          ok,
    output logic          err,
    output logic          busy,
    output logic [CW-1:0] cb_bit,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [CW-1:0] CB_N   = CW'(N);
    localparam logic [CW-1:0] CB_MAX = CW'(N + 1);

    state_t state, state_next;

    // Synchronizer stages (s1, s2) plus a third stage holding the previous
    // synchronized value for edge detection.
    logic sclk_s1, sclk_s2, sclk_s3;
    logic load_s1, load_s2, load_s3;
    logic mosi_s1, mosi_s2, mosi_s3;

    // Registered edge flags; mosi_s3 is aligned with them so the data bit
    // used on an SCLK rise is the one present at the pin with that edge.
    logic sclk_rise, sclk_fall, load_rise, load_fall;

    logic [N-1:0] sr_stx;
    logic [N-1:0] sr_srx;
    logic         fall_pend;   // LOAD fall seen in DONE, taken in IDLE

    logic start_frame;
    assign start_frame = load_fall | fall_pend;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_s3   <= 1'b0;
            load_s1   <= 1'b1;
            load_s2   <= 1'b1;
            load_s3   <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            mosi_s3   <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            load_rise <= 1'b0;
            load_fall <= 1'b0;
        end else begin
            sclk_s1   <= SCLK;
            sclk_s2   <= sclk_s1;
            sclk_s3   <= sclk_s2;
            load_s1   <= LOAD;
            load_s2   <= load_s1;
            load_s3   <= load_s2;
            mosi_s1   <= MOSI;
            mosi_s2   <= mosi_s1;
            mosi_s3   <= mosi_s2;
            sclk_rise <= sclk_s2 & ~sclk_s3;
            sclk_fall <= ~sclk_s2 & sclk_s3;
            load_rise <= load_s2 & ~load_s3;
            load_fall <= ~load_s2 & load_s3;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start_frame) state_next = S_ACTIVE;
            S_ACTIVE: if (load_rise)   state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sr_stx    <= '0;
            sr_srx    <= '0;
            cb_bit    <= '0;
            DO        <= '0;
            ok        <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            fall_pend <= 1'b0;
        end else begin
            ok   <= 1'b0;
            err  <= 1'b0;
            busy <= (state_next == S_ACTIVE);
            case (state)
                S_IDLE: begin
                    if (start_frame) begin
                        sr_stx    <= DI;
                        sr_srx    <= '0;
                        cb_bit    <= '0;
                        fall_pend <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    // SCLK edges are handled here regardless of a LOAD rise
                    // in the same cycle, so a coincident last edge counts.
                    if (sclk_rise) begin
                        sr_srx <= {sr_srx[N-2:0], mosi_s3};
                        if (cb_bit != CB_MAX) cb_bit <= cb_bit + 1'b1;
                    end
                    // No shift before the first bit so MISO keeps DI[N-1]
                    // even if the master parks SCLK high before the frame.
                    if (sclk_fall && (cb_bit != '0)) begin
                        sr_stx <= {sr_stx[N-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    if (cb_bit == CB_N) begin
                        DO <= sr_srx;
                        ok <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    if (load_fall) fall_pend <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign MISO      = (state == S_ACTIVE) ? sr_stx[N-1] : 1'b0;
    assign state_dbg = state;

endmodule
